gpr_writeback_queue: RTL

Write-side front end for the 32×32 general-purpose register file. It collects destination results from the single-cycle ALU path and the variable-latency load path, keeps them in program order, and drives the register file write port (`RegWrite`, `WriteRegisterSelect`, `WriteData`) with at most one write per cycle. It also reports which registers still have queued writes so decode can interlock on read operands.

---
 rtl/gpr_writeback_queue.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/gpr_writeback_queue.sv
// Purpose : in-order write-back queue in front of the 32x32 GPR write port; merges ALU and load results.
// Latency : 1 cycle from acceptance to RegWrite when the queue is empty; queued results drain one per cycle.
// Backpressure: MemReady drops and Stall rises at count >= DEPTH-1, which keeps two free slots for a dual arrival.
//
// Ports:
//   CLK, RST_N                      clock, asynchronous active-low reset
//   AluValid/AluReg/AluData         single-cycle ALU result (no handshake; must be idle while Stall)
//   MemValid/MemReg/MemData/MemReady load result with valid/ready handshake
//   Stall                           upstream ALU issue hold
//   RegWrite/WriteRegisterSelect/WriteData  registered register-file write port
//   ReadRegister1/2, Pending1/2     decode operand interlock (outstanding-write lookup)
//   FwdValid1/2, FwdData1/2         youngest outstanding value, only when GPR_WB_FORWARD_EN is defined
//
// Optional feature macro: GPR_WB_FORWARD_EN (forwarding ports and youngest-match selection).

module gpr_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        AluValid,
  input  logic [4:0]  AluReg,
  input  logic [31:0] AluData,
  input  logic        MemValid,
  input  logic [4:0]  MemReg,
  input  logic [31:0] MemData,
  output logic        MemReady,
  output logic        Stall,
  output logic        RegWrite,
  output logic [4:0]  WriteRegisterSelect,
  output logic [31:0] WriteData,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic        Pending1,
  output logic        Pending2
`ifdef GPR_WB_FORWARD_EN
  ,
  output logic        FwdValid1,
  output logic        FwdValid2,
  output logic [31:0] FwdData1,
  output logic [31:0] FwdData2
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    qReg  [DEPTH];
  logic [31:0]   qData [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;

  logic        memKeep, aluKeep;
  logic        firstVld, secondVld;
  logic [4:0]  firstReg;
  logic [31:0] firstData;
  logic        popHead;
  logic        enqAVld, enqBVld;
  logic [4:0]  enqAReg;
  logic [31:0] enqAData;

  assign MemReady = (count < CW'(DEPTH - 1));
  assign Stall    = ~MemReady;

  // Destination R0 results are accepted but dropped here. An ALU result
  // presented while Stall is high is illegal and is not accepted.
  assign memKeep = MemValid & MemReady & (MemReg != 5'd0);
  assign aluKeep = AluValid & ~Stall & (AluReg != 5'd0);

  // Arrivals in program order: the load is older than a same-cycle ALU result.
  assign firstVld  = memKeep | aluKeep;
  assign firstReg  = memKeep ? MemReg  : AluReg;
  assign firstData = memKeep ? MemData : AluData;
  assign secondVld = memKeep & aluKeep;

  // A non-empty queue always issues its head, so every arrival is queued behind it.
  // An empty queue sends the oldest arrival straight out and queues only the second.
  assign popHead  = (count != '0);
  assign enqAVld  = popHead ? firstVld  : secondVld;
  assign enqAReg  = popHead ? firstReg  : AluReg;
  assign enqAData = popHead ? firstData : AluData;
  assign enqBVld  = popHead & secondVld;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wrPtr               <= '0;
      rdPtr               <= '0;
      count               <= '0;
      RegWrite            <= 1'b0;
      WriteRegisterSelect <= 5'd0;
      WriteData           <= 32'd0;
    end else begin
      wrPtr <= wrPtr + PW'(enqAVld) + PW'(enqBVld);
      rdPtr <= rdPtr + PW'(popHead);
      count <= count + CW'(enqAVld) + CW'(enqBVld) - CW'(popHead);
      if (popHead) begin
        RegWrite            <= 1'b1;
        WriteRegisterSelect <= qReg[rdPtr];
        WriteData           <= qData[rdPtr];
      end else if (firstVld) begin
        RegWrite            <= 1'b1;
        WriteRegisterSelect <= firstReg;
        WriteData           <= firstData;
      end else begin
        // Address and data hold; only the enable drops.
        RegWrite <= 1'b0;
      end
    end
  end

  // Entry storage needs no reset: an entry is only meaningful inside [rdPtr, rdPtr+count).
  always_ff @(posedge CLK) begin
    if (enqAVld) begin
      qReg[wrPtr]  <= enqAReg;
      qData[wrPtr] <= enqAData;
    end
    if (enqBVld) begin
      qReg[wrPtr + PW'(1)]  <= AluReg;
      qData[wrPtr + PW'(1)] <= AluData;
    end
  end

  // Operand lookup. Same-cycle arrivals are deliberately not visible.
  // Scanning oldest to youngest lets the youngest match overwrite older ones,
  // and the output register (older than every queued entry) seeds the scan.
  logic [4:0]    rdSel [2];
  logic          hit   [2];
  logic [PW-1:0] idx;
`ifdef GPR_WB_FORWARD_EN
  logic [31:0]   hitData [2];
`endif

  always_comb begin
    rdSel[0] = ReadRegister1;
    rdSel[1] = ReadRegister2;
    idx      = rdPtr;
    for (int p = 0; p < 2; p++) begin
      hit[p] = RegWrite & (WriteRegisterSelect == rdSel[p]);
`ifdef GPR_WB_FORWARD_EN
      hitData[p] = WriteData;
`endif
      for (int k = 0; k < DEPTH; k++) begin
        idx = rdPtr + PW'(k);
        if ((CW'(k) < count) && (qReg[idx] == rdSel[p])) begin
          hit[p] = 1'b1;
`ifdef GPR_WB_FORWARD_EN
          hitData[p] = qData[idx];
`endif
        end
      end
    end
  end

  assign Pending1 = hit[0] & (ReadRegister1 != 5'd0);
  assign Pending2 = hit[1] & (ReadRegister2 != 5'd0);

`ifdef GPR_WB_FORWARD_EN
  assign FwdValid1 = Pending1;
  assign FwdValid2 = Pending2;
  assign FwdData1  = Pending1 ? hitData[0] : 32'd0;
  assign FwdData2  = Pending2 ? hitData[1] : 32'd0;
`endif

endmodule
